rx_tlp_mwr_decoder: RTL and testbench

//  Consumes the 64-bit TRN RX Local-Link stream of the PCIe endpoint (trn_rdst_rdy_n is tied low:

---
 rtl/rx_tlp_mwr_decoder.sv | 250 +++++++++++++++++++++++++
 tb/tb_rx_tlp_mwr_decoder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_tlp_mwr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rx_tlp_mwr_decoder
// Description : Parses the 64-bit TRN RX stream, extracts 1/2-DW MWr32/MWr64
//               TLPs hitting the selected BAR and turns each payload DW into a
//               32-bit register-write strobe. Everything else is consumed and
//               counted in a saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_tlp_mwr_decoder #(
    parameter int BAR_SEL = 0,
    parameter int ADDR_W  = 10
) (
    input  logic              trn_clk,
    input  logic              trn_reset_n,
    input  logic [63:0]       trn_rd,
    input  logic [7:0]        trn_rrem_n,
    input  logic              trn_rsof_n,
    input  logic              trn_reof_n,
    input  logic              trn_rsrc_rdy_n,
    input  logic              trn_rsrc_dsc_n,
    input  logic [6:0]        trn_rbar_hit_n,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [31:0]       reg_wr_data,
    output logic [3:0]        reg_wr_be,
    output logic [15:0]       drop_cnt
);

    localparam logic [7:0] C_REM_2DW = 8'h00;
    localparam logic [7:0] C_REM_1DW = 8'h0F;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_A3   = 3'd1,
        S_A4   = 3'd2,
        S_D0   = 3'd3,
        S_D1   = 3'd4,
        S_SKIP = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_len2;
    logic [3:0]          r_fbe;
    logic [3:0]          r_lbe;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_data0;

    // Commit stage: a TLP that ended cleanly, waiting to be strobed out
    logic                r_cm_valid;
    logic                r_cm_len2;
    logic [ADDR_W-1:0]   r_cm_addr;
    logic [31:0]         r_cm_d0;
    logic [31:0]         r_cm_d1;
    logic [3:0]          r_cm_fbe;
    logic [3:0]          r_cm_lbe;

    // One-entry buffer for the second DW of a 2-DW write
    logic                r_pd_valid;
    logic [ADDR_W-1:0]   r_pd_addr;
    logic [31:0]         r_pd_data;
    logic [3:0]          r_pd_be;

    logic                w_beat;
    logic                w_sof;
    logic                w_eof;
    logic                w_dsc;
    logic                w_rem2;
    logic                w_rem1;
    logic                w_hdr_ok;
    logic                w_is4dw;
    logic                w_len2;
    logic                w_active;
    logic [1:0]          w_drop_inc;
    logic                w_commit;
    logic [ADDR_W-1:0]   w_cm_addr;
    logic [31:0]         w_cm_d0;
    logic [31:0]         w_cm_d1;
    logic [16:0]         w_cnt_sum;
    logic                w_unused;

    // PCIe byte 0 travels in the MSB of a DW; registers want it in [7:0]
    function automatic logic [31:0] f_bswap(input logic [31:0] dw);
        return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
    endfunction

    assign w_beat   = ~trn_rsrc_rdy_n;
    assign w_sof    = ~trn_rsof_n;
    assign w_eof    = ~trn_reof_n;
    assign w_dsc    = ~trn_rsrc_dsc_n;
    assign w_rem2   = (trn_rrem_n == C_REM_2DW);
    assign w_rem1   = (trn_rrem_n == C_REM_1DW);
    assign w_is4dw  = trn_rd[61];
    assign w_len2   = (trn_rd[41:32] == 10'd2);
    assign w_hdr_ok = trn_rd[62] && (trn_rd[60:56] == 5'd0)
                   && ((trn_rd[41:32] == 10'd1) || w_len2)
                   && !trn_rbar_hit_n[BAR_SEL];
    assign w_active = (r_state == S_A3) || (r_state == S_A4)
                   || (r_state == S_D0) || (r_state == S_D1);
    assign w_cnt_sum = {1'b0, drop_cnt} + {15'd0, w_drop_inc};
    assign w_unused  = ^{trn_rd, trn_rbar_hit_n};

    // Per-beat verdict: how many TLPs are dropped this cycle, and whether one commits
    always_comb begin
        w_drop_inc = 2'd0;
        w_commit   = 1'b0;
        w_cm_addr  = r_addr;
        w_cm_d0    = f_bswap(trn_rd[63:32]);
        w_cm_d1    = f_bswap(trn_rd[31:0]);
        if (w_dsc) begin
            w_drop_inc = {1'b0, w_active};
        end else if (w_beat) begin
            if (w_sof) begin
                w_drop_inc = {1'b0, w_active} + {1'b0, (!w_hdr_ok || w_eof)};
            end else begin
                case (r_state)
                    S_A3: begin
                        w_cm_addr = trn_rd[ADDR_W+33:34];
                        w_cm_d0   = f_bswap(trn_rd[31:0]);
                        if (!r_len2 && w_eof && w_rem2)
                            w_commit = 1'b1;
                        else if (!(r_len2 && !w_eof))
                            w_drop_inc = 2'd1;
                    end
                    S_A4: begin
                        if (w_eof)
                            w_drop_inc = 2'd1;
                    end
                    S_D0: begin
                        if (w_eof && (r_len2 ? w_rem2 : w_rem1))
                            w_commit = 1'b1;
                        else
                            w_drop_inc = 2'd1;
                    end
                    S_D1: begin
                        w_cm_d0 = f_bswap(r_data0);
                        w_cm_d1 = f_bswap(trn_rd[63:32]);
                        if (w_eof && w_rem1)
                            w_commit = 1'b1;
                        else
                            w_drop_inc = 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Parser FSM, drop counter and commit-stage capture
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            r_state    <= S_IDLE;
            r_len2     <= 1'b0;
            r_fbe      <= 4'd0;
            r_lbe      <= 4'd0;
            r_addr     <= '0;
            r_data0    <= 32'd0;
            r_cm_valid <= 1'b0;
            r_cm_len2  <= 1'b0;
            r_cm_addr  <= '0;
            r_cm_d0    <= 32'd0;
            r_cm_d1    <= 32'd0;
            r_cm_fbe   <= 4'd0;
            r_cm_lbe   <= 4'd0;
            drop_cnt   <= 16'd0;
        end else begin
            r_cm_valid <= w_commit;
            if (w_commit) begin
                r_cm_len2 <= r_len2;
                r_cm_addr <= w_cm_addr;
                r_cm_d0   <= w_cm_d0;
                r_cm_d1   <= w_cm_d1;
                r_cm_fbe  <= r_fbe;
                r_cm_lbe  <= r_lbe;
            end
            if (w_drop_inc != 2'd0)
                drop_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];

            if (w_dsc) begin
                r_state <= S_IDLE;
            end else if (w_beat) begin
                if (w_sof) begin
                    r_len2 <= w_len2;
                    r_fbe  <= trn_rd[3:0];
                    r_lbe  <= trn_rd[7:4];
                    if (w_hdr_ok && !w_eof)
                        r_state <= w_is4dw ? S_A4 : S_A3;
                    else if (w_eof)
                        r_state <= S_IDLE;
                    else
                        r_state <= S_SKIP;
                end else begin
                    case (r_state)
                        S_A3: begin
                            r_addr  <= trn_rd[ADDR_W+33:34];
                            r_data0 <= trn_rd[31:0];
                            if (r_len2 && !w_eof)
                                r_state <= S_D1;
                            else if (w_eof)
                                r_state <= S_IDLE;
                            else
                                r_state <= S_SKIP;
                        end
                        S_A4: begin
                            r_addr  <= trn_rd[ADDR_W+1:2];
                            r_state <= w_eof ? S_IDLE : S_D0;
                        end
                        S_D0, S_D1: r_state <= w_eof ? S_IDLE : S_SKIP;
                        S_SKIP: if (w_eof) r_state <= S_IDLE;
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    // Strobe generator: write0 from the commit stage, write1 from the pending buffer
    always_ff @(posedge trn_clk or negedge trn_reset_n) begin
        if (!trn_reset_n) begin
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= 32'd0;
            reg_wr_be   <= 4'd0;
            r_pd_valid  <= 1'b0;
            r_pd_addr   <= '0;
            r_pd_data   <= 32'd0;
            r_pd_be     <= 4'd0;
        end else begin
            reg_wr_en <= 1'b0;
            if (r_pd_valid) begin
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= r_pd_addr;
                reg_wr_data <= r_pd_data;
                reg_wr_be   <= r_pd_be;
                r_pd_valid  <= 1'b0;
            end else if (r_cm_valid) begin
                reg_wr_en   <= 1'b1;
                reg_wr_addr <= r_cm_addr;
                reg_wr_data <= r_cm_d0;
                reg_wr_be   <= r_cm_fbe;
                r_pd_valid  <= r_cm_len2;
                r_pd_addr   <= r_cm_addr + ADDR_W'(1);
                r_pd_data   <= r_cm_d1;
                r_pd_be     <= r_cm_lbe;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_tlp_mwr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_tlp_mwr_decoder
// Description : Directed + randomized bench for rx_tlp_mwr_decoder with a
//               TLP-level reference model (expected writes and drop count).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_tlp_mwr_decoder;

    localparam int         ADDR_W   = 10;
    localparam int         BAR_SEL  = 0;
    localparam logic [6:0] BAR_HIT0 = 7'b1111110;
    localparam logic [6:0] BAR_HIT2 = 7'b1111011;

    logic              trn_clk = 1'b0;
    logic              trn_reset_n;
    logic [63:0]       trn_rd;
    logic [7:0]        trn_rrem_n;
    logic              trn_rsof_n;
    logic              trn_reof_n;
    logic              trn_rsrc_rdy_n;
    logic              trn_rsrc_dsc_n;
    logic [6:0]        trn_rbar_hit_n;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [31:0]       reg_wr_data;
    logic [3:0]        reg_wr_be;
    logic [15:0]       drop_cnt;

    rx_tlp_mwr_decoder #(.BAR_SEL(BAR_SEL), .ADDR_W(ADDR_W)) dut (
        .trn_clk        (trn_clk),
        .trn_reset_n    (trn_reset_n),
        .trn_rd         (trn_rd),
        .trn_rrem_n     (trn_rrem_n),
        .trn_rsof_n     (trn_rsof_n),
        .trn_reof_n     (trn_reof_n),
        .trn_rsrc_rdy_n (trn_rsrc_rdy_n),
        .trn_rsrc_dsc_n (trn_rsrc_dsc_n),
        .trn_rbar_hit_n (trn_rbar_hit_n),
        .reg_wr_en      (reg_wr_en),
        .reg_wr_addr    (reg_wr_addr),
        .reg_wr_data    (reg_wr_data),
        .reg_wr_be      (reg_wr_be),
        .drop_cnt       (drop_cnt)
    );

    always #5 trn_clk = ~trn_clk;

    int cyc = 0;
    always @(posedge trn_clk) cyc <= cyc + 1;

    typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; logic [3:0] be; int t; } wr_t;
    typedef struct { logic [63:0] d; logic sof; logic eof; logic [7:0] rem; } beat_t;

    wr_t   obsq[$];
    wr_t   expq[$];
    beat_t txq[$];
    int    vectors    = 0;
    int    miscompares = 0;
    int    exp_drop   = 0;
    int    sof_t      = 0;

    // Collect every strobe with the cycle it was visible in
    always @(negedge trn_clk) begin
        wr_t w;
        if (reg_wr_en === 1'b1) begin
            w.a  = reg_wr_addr;
            w.d  = reg_wr_data;
            w.be = reg_wr_be;
            w.t  = cyc;
            obsq.push_back(w);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Register view of a wire DW: PCIe byte k (k-th byte from the top) lands in byte lane k
    function automatic logic [31:0] le32(input logic [31:0] dw);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = dw[31-8*k -: 8];
        return r;
    endfunction

    function automatic logic [63:0] hdr(input logic [1:0] fmt, input logic [4:0] typ,
                                        input logic [9:0] len, input logic [3:0] fbe,
                                        input logic [3:0] lbe);
        logic [31:0] dw0;
        dw0        = 32'd0;
        dw0[30:29] = fmt;
        dw0[28:24] = typ;
        dw0[9:0]   = len;
        return {dw0, 16'hABCD, 8'h5A, lbe, fbe};
    endfunction

    task automatic idle_cycle(input bit junk);
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        if (junk) begin
            trn_rd         = {$urandom(), $urandom()};
            trn_rsof_n     = 1'($urandom_range(0, 1));
            trn_reof_n     = 1'($urandom_range(0, 1));
            trn_rrem_n     = 8'($urandom());
            trn_rbar_hit_n = 7'($urandom());
        end else begin
            trn_rsof_n = 1'b1;
            trn_reof_n = 1'b1;
        end
        @(posedge trn_clk); #1;
    endtask

    task automatic add_beat(input logic [63:0] d, input logic sof, input logic eof, input logic [7:0] rem);
        beat_t b;
        b.d = d; b.sof = sof; b.eof = eof; b.rem = rem;
        txq.push_back(b);
    endtask

    task automatic add_mwr(input bit is64, input int len, input logic [31:0] addr,
                           input logic [31:0] d0, input logic [31:0] d1,
                           input logic [3:0] fbe, input logic [3:0] lbe);
        logic [31:0] hi;
        hi = $urandom();
        add_beat(hdr(is64 ? 2'b11 : 2'b10, 5'd0, 10'(len), fbe, lbe), 1'b1, 1'b0, 8'h00);
        if (!is64) begin
            add_beat({addr, d0}, 1'b0, len == 1, 8'h00);
            if (len == 2) add_beat({d1, 32'hDEADBEEF}, 1'b0, 1'b1, 8'h0F);
        end else begin
            add_beat({hi, addr}, 1'b0, 1'b0, 8'h00);
            add_beat({d0, (len == 2) ? d1 : 32'hDEADBEEF}, 1'b0, 1'b1, (len == 2) ? 8'h00 : 8'h0F);
        end
    endtask

    // Expected strobes for an accepted write: DW address = byte address / 4, wrapping at 2^ADDR_W
    task automatic exp_mwr(input int len, input logic [31:0] addr, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [3:0] fbe, input logic [3:0] lbe);
        wr_t w;
        int unsigned base;
        base = (addr / 4) % (1 << ADDR_W);
        w.a = base[ADDR_W-1:0]; w.d = le32(d0); w.be = fbe; w.t = 0;
        expq.push_back(w);
        if (len == 2) begin
            base = (base + 1) % (1 << ADDR_W);
            w.a = base[ADDR_W-1:0]; w.d = le32(d1); w.be = lbe;
            expq.push_back(w);
        end
    endtask

    task automatic play(input bit gaps, input logic [6:0] bar, input int dsc_at);
        for (int i = 0; i < txq.size(); i++) begin
            if (gaps && i > 0) repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
            trn_rsrc_rdy_n = 1'b0;
            trn_rd         = txq[i].d;
            trn_rsof_n     = !txq[i].sof;
            trn_reof_n     = !txq[i].eof;
            trn_rrem_n     = txq[i].rem;
            trn_rbar_hit_n = bar;
            trn_rsrc_dsc_n = (i == dsc_at) ? 1'b0 : 1'b1;
            if (txq[i].sof) sof_t = cyc;
            @(posedge trn_clk); #1;
        end
        txq.delete();
        trn_rsrc_rdy_n = 1'b1;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
    endtask

    task automatic check_writes(input string tag, input int lat);
        int n;
        repeat (8) idle_cycle(1'b0);
        chk({tag, "_count"}, 64'(obsq.size()), 64'(expq.size()));
        n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 64'(obsq[i].a), 64'(expq[i].a));
            chk({tag, "_data"}, 64'(obsq[i].d), 64'(expq[i].d));
            chk({tag, "_be"},   64'(obsq[i].be), 64'(expq[i].be));
        end
        if (lat > 0 && obsq.size() > 0)
            chk({tag, "_latency"}, 64'(obsq[0].t - sof_t), 64'(lat));
        obsq.delete();
        expq.delete();
    endtask

    initial begin
        int          kind;
        bit          is64;
        int          len;
        logic [31:0] addr, d0, d1;
        logic [3:0]  fbe, lbe;

        trn_reset_n    = 1'b0;
        trn_rd         = 64'd0;
        trn_rrem_n     = 8'h00;
        trn_rsof_n     = 1'b1;
        trn_reof_n     = 1'b1;
        trn_rsrc_rdy_n = 1'b1;
        trn_rsrc_dsc_n = 1'b1;
        trn_rbar_hit_n = 7'h7F;
        repeat (3) @(posedge trn_clk);
        #1;
        chk("rst_en",   64'(reg_wr_en),   64'd0);
        chk("rst_addr", 64'(reg_wr_addr), 64'd0);
        chk("rst_data", 64'(reg_wr_data), 64'd0);
        chk("rst_be",   64'(reg_wr_be),   64'd0);
        chk("rst_drop", 64'(drop_cnt),    64'd0);
        trn_reset_n = 1'b1;
        repeat (2) idle_cycle(1'b0);

        // 1: MWr32 len1, bytes 11 22 33 44 at 0x10
        add_mwr(1'b0, 1, 32'h0000_0010, 32'h1122_3344, 32'h0, 4'hF, 4'h0);
        exp_mwr(1, 32'h0000_0010, 32'h1122_3344, 32'h0, 4'hF, 4'h0);
        play(1'b0, BAR_HIT0, -1);
        check_writes("t1", 3);

        // 2: MWr64 len2 wrapping the DW address
        add_mwr(1'b1, 2, 32'h0000_0FFC, 32'hA1B2_C3D4, 32'h0102_0304, 4'hF, 4'h3);
        exp_mwr(2, 32'h0000_0FFC, 32'hA1B2_C3D4, 32'h0102_0304, 4'hF, 4'h3);
        play(1'b0, BAR_HIT0, -1);
        check_writes("t2", 4);

        // 3: non-matching TLPs are swallowed and counted
        add_beat(hdr(2'b00, 5'd0, 10'd1, 4'hF, 4'h0), 1'b1, 1'b0, 8'h00);
        add_beat({32'h0000_0020, 32'h0}, 1'b0, 1'b1, 8'h0F);
        play(1'b0, BAR_HIT0, -1); exp_drop++;
        add_beat(hdr(2'b10, 5'b01010, 10'd1, 4'hF, 4'h0), 1'b1, 1'b0, 8'h00);
        add_beat({32'h0100_0000, 32'h5555_AAAA}, 1'b0, 1'b1, 8'h00);
        play(1'b0, BAR_HIT0, -1); exp_drop++;
        add_beat(hdr(2'b10, 5'd0, 10'd4, 4'hF, 4'hF), 1'b1, 1'b0, 8'h00);
        add_beat({32'h0000_0040, 32'h1}, 1'b0, 1'b0, 8'h00);
        add_beat({32'h2, 32'h3}, 1'b0, 1'b0, 8'h00);
        add_beat({32'h4, 32'h0}, 1'b0, 1'b1, 8'h0F);
        play(1'b0, BAR_HIT0, -1); exp_drop++;
        add_mwr(1'b0, 1, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 4'hF, 4'h0);
        play(1'b0, BAR_HIT2, -1); exp_drop++;
        repeat (2) idle_cycle(1'b0);
        chk("t3_drop4", 64'(drop_cnt), 64'(exp_drop));
        add_beat(hdr(2'b00, 5'd0, 10'd1, 4'hF, 4'h0), 1'b1, 1'b1, 8'h00);
        play(1'b0, BAR_HIT0, -1); exp_drop++;
        check_writes("t3", 0);
        chk("t3_drop5", 64'(drop_cnt), 64'(exp_drop));

        // 4: two MWr32 len2 with no idle beat between them
        add_mwr(1'b0, 2, 32'h0000_0100, 32'h0A0B_0C0D, 32'h1A1B_1C1D, 4'hF, 4'hC);
        add_mwr(1'b0, 2, 32'h0000_0200, 32'h2A2B_2C2D, 32'h3A3B_3C3D, 4'h1, 4'h8);
        exp_mwr(2, 32'h0000_0100, 32'h0A0B_0C0D, 32'h1A1B_1C1D, 4'hF, 4'hC);
        exp_mwr(2, 32'h0000_0200, 32'h2A2B_2C2D, 32'h3A3B_3C3D, 4'h1, 4'h8);
        play(1'b0, BAR_HIT0, -1);
        check_writes("t4", 0);

        // 5: discontinue on the data beat, then a clean write; once tight, once with gaps
        for (int g = 0; g < 2; g++) begin
            add_mwr(1'b1, 2, 32'h0000_0300, 32'hDEAD_0001, 32'hDEAD_0002, 4'hF, 4'hF);
            play(g[0], BAR_HIT0, 2); exp_drop++;
            add_mwr(1'b0, 1, 32'h0000_0304, 32'h7766_5544, 32'h0, 4'h6, 4'h0);
            exp_mwr(1, 32'h0000_0304, 32'h7766_5544, 32'h0, 4'h6, 4'h0);
            play(g[0], BAR_HIT0, -1);
            check_writes("t5", 0);
            chk("t5_drop", 64'(drop_cnt), 64'(exp_drop));
        end

        // Random mix of good, wrong-BAR, oversize, early-EOF and late-EOF TLPs
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            is64 = 1'($urandom_range(0, 1));
            len  = $urandom_range(1, 2);
            addr = $urandom(); d0 = $urandom(); d1 = $urandom();
            fbe  = 4'($urandom_range(0, 15));
            lbe  = 4'($urandom_range(0, 15));
            case (kind)
                0: begin
                    add_mwr(is64, len, addr, d0, d1, fbe, lbe);
                    exp_mwr(len, addr, d0, d1, fbe, lbe);
                    play(1'b1, BAR_HIT0, -1);
                end
                1: begin
                    add_mwr(is64, len, addr, d0, d1, fbe, lbe);
                    play(1'b1, {6'($urandom()), 1'b1}, -1); exp_drop++;
                end
                2: begin
                    add_beat(hdr(2'b10, 5'd0, 10'd3, fbe, lbe), 1'b1, 1'b0, 8'h00);
                    add_beat({addr, d0}, 1'b0, 1'b0, 8'h00);
                    add_beat({d1, d0}, 1'b0, 1'b1, 8'h00);
                    play(1'b1, BAR_HIT0, -1); exp_drop++;
                end
                3: begin
                    add_mwr(is64, len, addr, d0, d1, fbe, lbe);
                    void'(txq.pop_back());
                    txq[txq.size()-1].eof = 1'b1;
                    txq[txq.size()-1].rem = 8'h00;
                    play(1'b1, BAR_HIT0, -1); exp_drop++;
                end
                default: begin
                    add_mwr(is64, len, addr, d0, d1, fbe, lbe);
                    txq[txq.size()-1].eof = 1'b0;
                    add_beat({d0, d1}, 1'b0, 1'b1, 8'h00);
                    play(1'b1, BAR_HIT0, -1); exp_drop++;
                end
            endcase
            repeat ($urandom_range(0, 1)) idle_cycle(1'b1);
        end
        check_writes("rand", 0);
        chk("rand_drop", 64'(drop_cnt), 64'(exp_drop));

        // 6: asynchronous reset in the middle of a TLP
        add_mwr(1'b0, 2, 32'h0000_0050, 32'h1357_9BDF, 32'h2468_ACE0, 4'hF, 4'hF);
        void'(txq.pop_back());
        play(1'b0, BAR_HIT0, -1);
        #2 trn_reset_n = 1'b0;
        #1;
        chk("t6_en",   64'(reg_wr_en),   64'd0);
        chk("t6_addr", 64'(reg_wr_addr), 64'd0);
        chk("t6_data", 64'(reg_wr_data), 64'd0);
        chk("t6_be",   64'(reg_wr_be),   64'd0);
        chk("t6_drop", 64'(drop_cnt),    64'd0);
        repeat (2) @(posedge trn_clk);
        #1 trn_reset_n = 1'b1;
        obsq.delete();
        expq.delete();
        exp_drop = 0;
        add_beat({32'h0000_0054, 32'h0000_0000}, 1'b0, 1'b1, 8'h0F);
        play(1'b0, BAR_HIT0, -1);
        add_mwr(1'b0, 1, 32'h0000_0060, 32'hF00D_BEEF, 32'h0, 4'h0, 4'h0);
        exp_mwr(1, 32'h0000_0060, 32'hF00D_BEEF, 32'h0, 4'h0, 4'h0);
        play(1'b0, BAR_HIT0, -1);
        check_writes("t6", 3);
        chk("t6_drop_after", 64'(drop_cnt), 64'(exp_drop));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
